// File: rtl/tt_check_pkg.sv
// Shared types and constants for the 3-input truth-table sweep checker.
package tt_check_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        CHECK,
        FINISH
    } tt_state_t;

    localparam int N_VECTORS = 8;
    localparam int CNT_W     = 4;
    localparam int VEC_W     = 3;

    // Settle time must fit the counter and leave at least one hold cycle.
    function automatic logic settle_legal(input int settle);
        return (settle >= 1) && (settle <= 15);
    endfunction

endpackage

// File: rtl/settle_counter.sv
// Loadable down-counter that times how long each vector is held before
// its check cycle. It stops at zero and reports that through `zero`.
import tt_check_pkg::*;

module settle_counter (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    // Count register: load has priority over decrement, never wraps below zero.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the values present before the edge.
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/tt3_sweep_checker.sv
// Sweeps all eight {a,b,c} vectors into a combinational block under test,
// samples its `y` after a settle time and records per-vector mismatches
// against a latched truth table.
import tt_check_pkg::*;

module tt3_sweep_checker #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [N_VECTORS-1:0] tt_expected,
    input  logic                 y,
    output logic                 a,
    output logic                 b,
    output logic                 c,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [N_VECTORS-1:0] fail_mask,
    output logic [CNT_W-1:0]     err_count
);

    generate
        if (!settle_legal(SETTLE_CYCLES)) begin : g_bad_settle
            $error("tt3_sweep_checker: SETTLE_CYCLES must be within 1..15");
        end
    endgenerate

    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [VEC_W-1:0] LAST_VEC    = VEC_W'(N_VECTORS - 1);

    tt_state_t            state;
    tt_state_t            state_next;
    logic [VEC_W-1:0]     idx;
    logic [N_VECTORS-1:0] tt_q;
    logic                 cnt_load;
    logic                 cnt_dec;
    logic                 cnt_zero;
    logic                 last_vec;
    logic                 mismatch;

    assign last_vec = (idx == LAST_VEC);
    assign mismatch = y ^ tt_q[idx];

    // The vector index doubles as the driven vector: a is the MSB, c the LSB.
    assign {a, b, c} = idx;

    settle_counter u_settle (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (SETTLE_LOAD),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode, settle-counter control and status outputs.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = WAIT;
                    cnt_load   = 1'b1;
                end
            end
            WAIT: begin
                busy = 1'b1;
                if (cnt_zero) begin
                    state_next = CHECK;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            CHECK: begin
                busy = 1'b1;
                if (last_vec) begin
                    state_next = FINISH;
                end else begin
                    state_next = WAIT;
                    cnt_load   = 1'b1;
                end
            end
            FINISH: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Sweep datapath: truth-table latch, vector stepping and result capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            tt_q      <= '0;
            idx       <= '0;
            fail_mask <= '0;
            err_count <= '0;
            pass      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        tt_q      <= tt_expected;
                        idx       <= '0;
                        fail_mask <= '0;
                        err_count <= '0;
                        pass      <= 1'b0;
                    end
                end
                CHECK: begin
                    // At most eight increments, so the 4-bit count never wraps.
                    if (mismatch) begin
                        fail_mask[idx] <= 1'b1;
                        err_count      <= err_count + CNT_W'(1);
                    end
                    if (!last_vec) begin
                        idx <= idx + VEC_W'(1);
                    end
                end
                FINISH: begin
                    pass <= (err_count == '0);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tt3_sweep_checker.sv
// Self-checking bench for tt3_sweep_checker: two instances (settle 2 and 1)
// share stimulus; expected outputs come from a cycle-indexed model of the
// sweep timing and truth-table comparison.
module tb_tt3_sweep_checker;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] tt_expected = 8'h00;
    logic       y = 1'b0;

    logic       a2, b2, c2, busy2, done2, pass2;
    logic [7:0] fm2;
    logic [3:0] ec2;
    logic       a1, b1, c1, busy1, done1, pass1;
    logic [7:0] fm1;
    logic [3:0] ec1;

    int errors = 0;
    int checks = 0;
    int sel_s  = 2;

    logic [17:0] obs;

    always #5 clk = ~clk;

    tt3_sweep_checker #(.SETTLE_CYCLES(2)) u_dut2 (
        .clk(clk), .reset(reset), .start(start), .tt_expected(tt_expected), .y(y),
        .a(a2), .b(b2), .c(c2), .busy(busy2), .done(done2), .pass(pass2),
        .fail_mask(fm2), .err_count(ec2)
    );

    tt3_sweep_checker #(.SETTLE_CYCLES(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start), .tt_expected(tt_expected), .y(y),
        .a(a1), .b(b1), .c(c1), .busy(busy1), .done(done1), .pass(pass1),
        .fail_mask(fm1), .err_count(ec1)
    );

    // Observed bundle: {vector[2:0], busy, done, pass, fail_mask[7:0], err_count[3:0]}.
    always_comb begin
        if (sel_s == 1) obs = {a1, b1, c1, busy1, done1, pass1, fm1, ec1};
        else            obs = {a2, b2, c2, busy2, done2, pass2, fm2, ec2};
    end

    // Expected outputs during cycle k after the start edge (cycle k follows edge k-1).
    function automatic logic [17:0] expect_at(input int s, input int k,
                                              input logic [7:0] tt, input logic [7:0] resp);
        int         p;
        int         last;
        logic [2:0] vec;
        logic       e_busy, e_done, e_pass;
        logic [7:0] mask;
        logic [3:0] cnt;
        p      = s + 1;
        last   = 8 * p;
        vec    = (k <= last) ? 3'((k - 1) / p) : 3'd7;
        e_busy = (k >= 1) && (k <= last);
        e_done = (k == last + 1);
        mask   = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (((i + 1) * p <= k - 1) && (tt[i] != resp[i])) mask[i] = 1'b1;
        end
        cnt    = 4'($countones(mask));
        e_pass = (k >= last + 2) ? (mask == 8'h00) : 1'b0;
        return {vec, e_busy, e_done, e_pass, mask, cnt};
    endfunction

    // Runs one sweep and compares every cycle up to the first IDLE cycle.
    // mode 0: single start pulse; mode 1: extra pulse at cycle 5, then start
    // held from cycle 10 so the next sweep starts at the first IDLE cycle.
    task automatic do_sweep(input int s, input logic [7:0] tt, input logic [7:0] resp,
                            input int mode, input bit tt_change, input bit started,
                            input string name);
        int          p;
        int          last;
        logic [17:0] exp_v;
        sel_s = s;
        p     = s + 1;
        last  = 8 * p;
        if (!started) begin
            @(negedge clk);
            checks++;
            if (obs[14:13] !== 2'b00)
                $display("FAIL %s idle_before_start busy_done got=%b exp=00", name, obs[14:13]);
            tt_expected = tt;
            start       = 1'b1;
            y           = 1'($urandom);
        end
        for (int k = 1; k <= last + 2; k++) begin
            @(negedge clk);
            exp_v = expect_at(s, k, tt, resp);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL %s cycle=%0d got=%h exp=%h", name, k, obs, exp_v);
            end
            start = (mode == 1) && (k == 5 || k >= 10);
            if (tt_change && k == 4) tt_expected = 8'h00;
            if ((k % p == 0) && (k <= last)) y = resp[k / p - 1];
            else                             y = 1'($urandom);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        tt_expected = 8'hFF;
        repeat (3) @(negedge clk);
        checks++;
        if ({obs, busy1, done1, pass1, fm1, ec1} !== '0) begin
            errors++;
            $display("FAIL reset_state got=%h exp=0", {obs, busy1, done1, pass1, fm1, ec1});
        end
        start = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_golden();
        apply_reset();
        do_sweep(2, 8'h39, 8'h39, 0, 1'b0, 1'b0, "golden");
    endtask

    task automatic test_stuck0();
        apply_reset();
        do_sweep(2, 8'h39, 8'h00, 0, 1'b0, 1'b0, "stuck0");
    endtask

    task automatic test_inverted();
        apply_reset();
        do_sweep(2, 8'h39, 8'hC6, 0, 1'b0, 1'b0, "inverted");
    endtask

    task automatic test_back_to_back();
        apply_reset();
        do_sweep(2, 8'h39, 8'h39, 1, 1'b0, 1'b0, "held_first");
        do_sweep(2, 8'h39, 8'h5A, 0, 1'b0, 1'b1, "held_second");
    endtask

    task automatic test_reset_mid_sweep();
        apply_reset();
        sel_s = 2;
        @(negedge clk);
        tt_expected = 8'h39;
        start       = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            start = 1'b0;
            checks++;
            if (obs[14] !== 1'b1) begin
                errors++;
                $display("FAIL midreset_busy cycle=%0d got=%b exp=1", k, obs[14]);
            end
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL midreset_outputs got=%h exp=0", obs);
        end
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            checks++;
            if (obs[14:13] !== 2'b00) begin
                errors++;
                $display("FAIL midreset_no_done cycle=%0d got=%b exp=00", k, obs[14:13]);
            end
        end
        do_sweep(2, 8'h39, 8'h39, 0, 1'b0, 1'b0, "after_reset");
    endtask

    task automatic test_tt_change();
        apply_reset();
        do_sweep(2, 8'h39, 8'h39, 0, 1'b1, 1'b0, "tt_change");
    endtask

    task automatic test_min_settle();
        apply_reset();
        do_sweep(1, 8'h39, 8'h39, 0, 1'b0, 1'b0, "min_settle");
    endtask

    task automatic test_random();
        int         s;
        logic [7:0] tt;
        logic [7:0] flip;
        for (int n = 0; n < 8; n++) begin
            s    = $urandom_range(1, 2);
            tt   = 8'($urandom);
            flip = 8'($urandom);
            if (n % 2 == 1) flip = flip & 8'($urandom);
            if (n == 0) flip = 8'h00;
            apply_reset();
            do_sweep(s, tt, tt ^ flip, 0, 1'b0, 1'b0, "random");
        end
    endtask

    initial begin
        test_reset();
        test_golden();
        test_stuck0();
        test_inverted();
        test_back_to_back();
        test_reset_mid_sweep();
        test_tt_change();
        test_min_settle();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
